// File: rtl/fns_pkg.sv
// rtl/fns_pkg.sv - Fibonacci constants and width helpers for the FNS encoder
package fns_pkg;

  // F(0)=0, F(1)=F(2)=1; evaluated at elaboration for thresholds and widths
  function automatic logic [63:0] fib(input int k);
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] t;
    a = 64'd0;
    b = 64'd1;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // smallest n with 2^n >= v
  function automatic int clog2(input logic [63:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 64; i++) begin
      if ((64'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // remainder entering bit k is < F(k+3)
  function automatic int fns_rem_w(input int k);
    return clog2(fib(k + 3));
  endfunction

  // number of representable values for a w-bit codeword
  function automatic logic [63:0] fns_cap(input int w);
    return fib(w + 2);
  endfunction

endpackage

// File: rtl/fns_enc_stage.sv
// rtl/fns_enc_stage.sv - one pipeline stage resolving NBITS code bits from TOP downward
module fns_enc_stage
  import fns_pkg::*;
#(
  parameter int CODE_W = 29,
  parameter int TOP    = 28,
  parameter int NBITS  = 4,
  parameter int RIN_W  = fns_rem_w(TOP),
  parameter int ROUT_W = (TOP - NBITS + 1 > 0) ? fns_rem_w(TOP - NBITS) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic              valid_i,
  input  logic              err_i,
  input  logic              carry_i,
  input  logic [RIN_W-1:0]  rem_i,
  input  logic [CODE_W-1:0] code_i,
  output logic              valid_o,
  output logic              err_o,
  output logic              carry_o,
  output logic [ROUT_W-1:0] rem_o,
  output logic [CODE_W-1:0] code_o
);

  // bits[NBITS-1] is code bit TOP, bits[0] is code bit TOP-NBITS+1
  logic [NBITS-1:0] bits;
  logic [RIN_W-1:0] r_fin;

  // threshold/copy chain; at bit 0 both thresholds are 1 so the bit equals the remainder
  for (genvar i = 0; i < NBITS; i++) begin : g_bit
    localparam logic [RIN_W-1:0] LO_T = RIN_W'(fib(TOP - i + 1));
    localparam logic [RIN_W-1:0] HI_T = RIN_W'(fib(TOP - i + 2));
    logic [RIN_W-1:0] r_in;
    logic [RIN_W-1:0] r_out;
    logic             b_prev;
    logic             b;
    if (i == 0) begin : g_first
      assign r_in   = rem_i;
      assign b_prev = carry_i;
    end else begin : g_next
      assign r_in   = g_bit[i-1].r_out;
      assign b_prev = g_bit[i-1].b;
    end
    assign b     = (r_in < LO_T) ? 1'b0 : ((r_in >= HI_T) ? 1'b1 : b_prev);
    assign r_out = b ? (r_in - LO_T) : r_in;
    assign bits[NBITS-1-i] = b;
  end

  assign r_fin = g_bit[NBITS-1].r_out;

  logic              valid_d, valid_q;
  logic              err_d, err_q;
  logic              carry_d, carry_q;
  logic [ROUT_W-1:0] rem_d, rem_q;
  logic [CODE_W-1:0] code_d, code_q;

  // load from predecessor when the pipeline advances, otherwise hold
  always_comb begin
    valid_d = valid_q;
    err_d   = err_q;
    carry_d = carry_q;
    rem_d   = rem_q;
    code_d  = code_q;
    if (en) begin
      valid_d = valid_i;
      err_d   = err_i;
      carry_d = bits[0];
      rem_d   = r_fin[ROUT_W-1:0];
      code_d  = code_i;
      code_d[TOP -: NBITS] = bits;
    end
  end

  // stage registers
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      carry_q <= 1'b0;
      rem_q   <= '0;
      code_q  <= '0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      carry_q <= carry_d;
      rem_q   <= rem_d;
      code_q  <= code_d;
    end
  end

  assign valid_o = valid_q;
  assign err_o   = err_q;
  assign carry_o = carry_q;
  assign rem_o   = rem_q;
  assign code_o  = code_q;

endmodule

// File: rtl/fns_cac_encoder_pipe.sv
// rtl/fns_cac_encoder_pipe.sv - pipelined FNS crosstalk-avoidance encoder with valid/ready
module fns_cac_encoder_pipe
  import fns_pkg::*;
#(
  parameter int CODE_W     = 29,
  parameter int STAGE_BITS = 4,
  parameter int DATA_W     = 21
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_seed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_err
);

  localparam int          NSTAGE = (CODE_W + STAGE_BITS - 1) / STAGE_BITS;
  localparam logic [63:0] CAP    = fns_cap(CODE_W);
  localparam int          RIN0_W = fns_rem_w(CODE_W - 1);

  logic              en;
  logic              in_err;
  logic              seed0;
  logic [RIN0_W-1:0] rem0;

  // global stall and range check; an out-of-range word enters as all zeros
  always_comb begin
    en     = !out_valid || out_ready;
    in_err = 64'(in_data) >= CAP;
    rem0   = in_err ? '0 : in_data[RIN0_W-1:0];
    seed0  = in_seed && !in_err;
  end

  assign in_ready = en;

  for (genvar s = 0; s < NSTAGE; s++) begin : g_stage
    localparam int TOP    = CODE_W - 1 - s * STAGE_BITS;
    localparam int NB     = (TOP + 1 < STAGE_BITS) ? TOP + 1 : STAGE_BITS;
    localparam int LO     = TOP - NB + 1;
    localparam int RIN_W  = fns_rem_w(TOP);
    localparam int ROUT_W = (LO > 0) ? fns_rem_w(LO - 1) : 1;

    logic              v_i, e_i, c_i;
    logic              v_o, e_o, c_o;
    logic [RIN_W-1:0]  r_i;
    logic [ROUT_W-1:0] r_o;
    logic [CODE_W-1:0] code_i;
    logic [CODE_W-1:0] code_o;

    if (s == 0) begin : g_head
      assign v_i    = in_valid;
      assign e_i    = in_err;
      assign c_i    = seed0;
      assign r_i    = rem0;
      assign code_i = '0;
    end else begin : g_link
      assign v_i    = g_stage[s-1].v_o;
      assign e_i    = g_stage[s-1].e_o;
      assign c_i    = g_stage[s-1].c_o;
      assign r_i    = g_stage[s-1].r_o;
      assign code_i = g_stage[s-1].code_o;
    end

    fns_enc_stage #(
      .CODE_W (CODE_W),
      .TOP    (TOP),
      .NBITS  (NB),
      .RIN_W  (RIN_W),
      .ROUT_W (ROUT_W)
    ) u_stage (
      .clock   (clock),
      .reset   (reset),
      .en      (en),
      .valid_i (v_i),
      .err_i   (e_i),
      .carry_i (c_i),
      .rem_i   (r_i),
      .code_i  (code_i),
      .valid_o (v_o),
      .err_o   (e_o),
      .carry_o (c_o),
      .rem_o   (r_o),
      .code_o  (code_o)
    );
  end

  assign out_valid = g_stage[NSTAGE-1].v_o;
  assign out_err   = g_stage[NSTAGE-1].e_o;
  assign out_code  = g_stage[NSTAGE-1].code_o;

endmodule

// File: tb/tb_fns_cac_encoder_pipe.sv
// tb/tb_fns_cac_encoder_pipe.sv - self-checking bench for the FNS encoder pipeline
module tb_fns_cac_encoder_pipe;

  localparam int NST_D = 8;
  localparam int NST_S = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        d_iv, d_ir, d_seed, d_ov, d_or, d_err;
  logic [20:0] d_data;
  logic [28:0] d_code;
  logic        s_iv, s_ir, s_seed, s_ov, s_or, s_err;
  logic [3:0]  s_data;
  logic [4:0]  s_code;

  fns_cac_encoder_pipe #(.CODE_W(29), .STAGE_BITS(4), .DATA_W(21)) dut_d (
    .clock(clock), .reset(reset), .in_valid(d_iv), .in_ready(d_ir), .in_data(d_data),
    .in_seed(d_seed), .out_valid(d_ov), .out_ready(d_or), .out_code(d_code), .out_err(d_err));

  fns_cac_encoder_pipe #(.CODE_W(5), .STAGE_BITS(2), .DATA_W(4)) dut_s (
    .clock(clock), .reset(reset), .in_valid(s_iv), .in_ready(s_ir), .in_data(s_data),
    .in_seed(s_seed), .out_valid(s_ov), .out_ready(s_or), .out_code(s_code), .out_err(s_err));

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  function automatic longint unsigned fibv(input int k);
    longint unsigned a, b, t;
    a = 0;
    b = 1;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // reference codeword {err, code}
  function automatic logic [64:0] enc(input int w, input longint unsigned d, input logic seed);
    longint unsigned r;
    logic            prev, b;
    logic [63:0]     code;
    if (d >= fibv(w + 2)) return {1'b1, 64'd0};
    r = d;
    prev = seed;
    code = '0;
    for (int k = w - 1; k >= 1; k--) begin
      if (r < fibv(k + 1)) b = 1'b0;
      else if (r >= fibv(k + 2)) b = 1'b1;
      else b = prev;
      if (b) r = r - fibv(k + 1);
      code[k] = b;
      prev = b;
    end
    code[0] = r[0];
    return {1'b0, code};
  endfunction

  function automatic longint unsigned dec(input int w, input logic [63:0] c);
    longint unsigned s;
    s = 0;
    for (int k = 0; k < w; k++) if (c[k]) s = s + fibv(k + 1);
    return s;
  endfunction

  function automatic logic clean(input int w, input logic [63:0] c);
    for (int k = 0; k + 2 < w; k++)
      if (c[k+2] != c[k+1] && c[k+1] != c[k]) return 1'b0;
    return 1'b1;
  endfunction

  typedef struct {
    int              id;
    logic [64:0]     exp;
    longint unsigned data;
    int              acc;
  } exp_t;

  exp_t        sb[$];
  int          en_cnt[2];
  logic        stalled[2];
  logic [63:0] hold_code[2];
  logic        hold_err[2];

  task automatic mon(input int id, input int w, input int nst, input logic iv, input logic ir,
                     input longint unsigned data, input logic seed, input logic ov,
                     input logic ordy, input logic [63:0] code, input logic err);
    int   idx;
    exp_t e;
    chk($sformatf("in_ready_rule%0d", id), ir, !ov || ordy);
    if (stalled[id]) begin
      chk($sformatf("hold_valid%0d", id), ov, 1'b1);
      chk($sformatf("hold_word%0d", id), {err, code}, {hold_err[id], hold_code[id]});
    end
    if (ov && ordy) begin
      idx = -1;
      foreach (sb[i]) if (idx < 0 && sb[i].id == id) idx = i;
      if (idx < 0) begin
        total++;
        $display("FAIL unexpected_out%0d: got code 0x%0h, want no output", id, code);
      end else begin
        e = sb[idx];
        sb.delete(idx);
        chk($sformatf("word%0d_%0d", id, e.data), {err, code}, e.exp);
        chk($sformatf("latency%0d", id), en_cnt[id] - e.acc, nst);
        if (!e.exp[64]) begin
          chk($sformatf("decode%0d", id), dec(w, code), e.data);
          chk($sformatf("no_alt%0d", id), clean(w, code), 1'b1);
        end
      end
    end
    stalled[id]   = ov && !ordy;
    hold_code[id] = code;
    hold_err[id]  = err;
    if (iv && ir) sb.push_back('{id: id, exp: enc(w, data, seed), data: data, acc: en_cnt[id]});
    if (ir) en_cnt[id]++;
  endtask

  // single compare process for both instances
  always @(negedge clock) begin
    if (reset) begin
      sb.delete();
      en_cnt  = '{0, 0};
      stalled = '{1'b0, 1'b0};
    end else begin
      mon(0, 29, NST_D, d_iv, d_ir, longint'(d_data), d_seed, d_ov, d_or, 64'(d_code), d_err);
      mon(1, 5, NST_S, s_iv, s_ir, longint'(s_data), s_seed, s_ov, s_or, 64'(s_code), s_err);
    end
  end

  task automatic send(input int id, input longint unsigned data, input logic seed);
    int waited;
    waited = 0;
    if (id == 0) begin d_iv = 1'b1; d_data = 21'(data); d_seed = seed; end
    else begin s_iv = 1'b1; s_data = 4'(data); s_seed = seed; end
    @(negedge clock);
    while (((id == 0) ? d_ir : s_ir) !== 1'b1 && waited < 50) begin
      waited++;
      @(negedge clock);
    end
    if (waited >= 50) begin
      total++;
      $display("FAIL send_timeout%0d: in_ready stayed low, want acceptance", id);
    end
    @(posedge clock);
    #1;
    if (id == 0) d_iv = 1'b0; else s_iv = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("drain_empty", sb.size(), 0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [20:0] w9;
    d_iv = 0; d_data = 0; d_seed = 0; d_or = 1;
    s_iv = 0; s_data = 0; s_seed = 0; s_or = 1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_out_valid", d_ov, 1'b0);
    chk("rst_out_code", d_code, 29'd0);
    chk("rst_out_err", d_err, 1'b0);
    chk("rst_in_ready", d_ir, 1'b1);
    chk("rst_small_valid", s_ov, 1'b0);
    chk("rst_small_code", s_code, 5'd0);
    @(posedge clock);
    #1;

    chk("model_w5_12", enc(5, 12, 1'b0), 65'h1F);
    chk("model_w5_6s0", enc(5, 6, 1'b0), 65'h0E);
    chk("model_w5_6s1", enc(5, 6, 1'b1), 65'h11);
    chk("model_w5_13", enc(5, 13, 1'b0), {1'b1, 64'd0});
    chk("model_w5_0", enc(5, 0, 1'b0), 65'h0);
    chk("model_w29_max", enc(29, 1346268, 1'b0), 65'h1FFFFFFF);
    chk("model_w29_0", enc(29, 0, 1'b1), 65'h0);
    chk("dec_01110", dec(5, 64'h0E), 6);
    chk("dec_10001", dec(5, 64'h11), 6);

    send(1, 12, 1'b0);
    @(posedge clock);
    #1;
    send(1, 6, 1'b0);
    send(1, 6, 1'b1);
    send(1, 13, 1'b0);
    send(1, 0, 1'b0);
    drain();

    send(0, 0, 1'b0);
    send(0, 1346268, 1'b1);
    for (int i = 0; i < 40; i++) send(0, $urandom_range(1346268), 1'($urandom_range(1)));
    drain();

    d_or = 1'b0;
    for (int i = 0; i < NST_D; i++) send(0, $urandom_range(1346268), 1'($urandom_range(1)));
    w9 = 21'($urandom_range(1346268));
    d_iv = 1'b1; d_data = w9; d_seed = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("stall_in_ready", d_ir, 1'b0);
      chk("stall_out_valid", d_ov, 1'b1);
    end
    @(posedge clock);
    #1 d_or = 1'b1;
    send(0, w9, 1'b0);
    drain();

    for (int i = 0; i < 3; i++) send(0, $urandom_range(1346268), 1'($urandom_range(1)));
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("midrst_out_valid", d_ov, 1'b0);
    chk("midrst_in_ready", d_ir, 1'b1);
    @(posedge clock);
    #1;
    send(0, 1346268, 1'b0);
    send(0, $urandom_range(1346268), 1'b1);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fns_cac_encoder_pipe.md
Name: fns_cac_encoder_pipe

Overview:
- Parametrised, pipelined successor of the fixed 29-bit IDP encoder.
- Maps a binary word onto a CODE_W-bit Fibonacci-numeral-system (FNS) crosstalk-avoidance codeword using the greedy threshold/copy rule.
- Resolves STAGE_BITS code bits per pipeline stage, with a valid/ready handshake, an out-of-range error flag, and a per-word seed for the top-bit copy decision.
- Sits between the TSV-bus source and the mosaic transmit register.

Parameters:
- CODE_W, 29, codeword width; must be ≥ 3.
- STAGE_BITS, 4, code bits resolved per stage; 1..CODE_W.
- DATA_W, 21, input width; must satisfy 2^DATA_W ≥ F(CODE_W+2).
- NSTAGE (localparam), ceil(CODE_W/STAGE_BITS), number of pipeline stages.

Ports:
- clock  in  1  single clock; all flops on the rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input word present.
- in_ready  out  1  encoder accepts this cycle.
- in_data  in  DATA_W  unsigned value to encode.
- in_seed  in  1  value copied into the top bit when the top decision is free.
- out_valid  out  1  codeword present.
- out_ready  in  1  sink accepts.
- out_code  out  CODE_W  codeword, MSB = bit CODE_W-1.
- out_err  out  1  input was ≥ F(CODE_W+2); qualified by out_valid.

Behaviour:
- Fibonacci numbering: F(1)=F(2)=1, F(k)=F(k-1)+F(k-2). Code bit k has weight F(k+1). Legal input range is 0..F(CODE_W+2)-1.
- Per-bit rule, applied from k=CODE_W-1 down to 1, with running remainder r (initially in_data):
  - if r < F(k+1), bit = 0;
  - else if r ≥ F(k+2), bit = 1;
  - else bit = previous, more significant bit (for k=CODE_W-1 the previous bit is in_seed).
  - If bit = 1, then r = r - F(k+1).
- Bit 0 = final r, which is guaranteed to be 0 or 1.
- The remainder at bit k is always < F(k+3). Remainder registers narrow per stage to clog2(F(k+3)) bits.
- Range check happens in stage 0, combinationally on in_data. If out of range: err bit set, remainder forced to 0, seed forced to 0, so out_code = 0.
- Stage s resolves bits CODE_W-1-s*STAGE_BITS downward. The last stage may be short. Each stage registers: valid, err, remainder, resolved code bits so far, and the most recently resolved bit (carry for the copy rule).
- Handshake uses a global enable: en = !out_valid | out_ready, and in_ready = en.
  - When en is high, every stage loads from its predecessor; stage 0 loads {in_valid, ...}.
  - When en is low, all stages hold.
  - Bubbles are not collapsed.
- Latency: exactly NSTAGE enabled cycles from an accepted input to out_valid. Throughput is 1 word/cycle while out_ready=1.
- out_code, out_err and out_valid are driven directly from the last stage registers, and are stable while out_valid & !out_ready.
- Reset: all valid bits, code, remainder and err registers clear to 0. The cycle after reset deasserts, out_valid=0, out_code=0, out_err=0, in_ready=1.
- Reset asserted mid-stream discards all in-flight words; no partial outputs appear.
- in_valid=0 while en=1 inserts a bubble; in_data and in_seed are don't-care for that cycle.
- All arithmetic is unsigned. F() constants are computed at elaboration. No overflow is possible on legal inputs.

Decomposition:
- Package fns_pkg holds:
  - constant function fib(k) (64-bit result);
  - function clog2;
  - function fns_rem_w(k) = clog2(fib(k+3));
  - a localparam capacity macro replacing the per-width FNS/FRLEN defines.
- One sub-module, fns_enc_stage, parameterised by top bit index and bit count. It implements the per-bit rule chain and the stage registers, and is instantiated NSTAGE times in a generate loop.

Test Plan:
- CODE_W=5, STAGE_BITS=2: in_data=12, seed=0 → out_code=5'b11111, err=0, out_valid exactly 3 cycles after acceptance.
- CODE_W=5: in_data=6, seed=0 → 5'b01110; in_data=6, seed=1 → 5'b10001; both decode back to 6.
- CODE_W=5: in_data=13 → out_err=1, out_code=0. The next word (in_data=0) → out_code=0, err=0.
- Default parameters: in_data=0 → all zeros; in_data=1346268 (F(31)-1) → all ones. Then back-to-back random legal words with out_ready=1 → one output per cycle; every codeword decodes (Σ bit_k·F(k+1)) to its input and has no 010/101 pattern.
- out_ready held low 5 cycles with a full pipeline → in_ready=0, outputs stable, no word lost or duplicated. Release → order preserved.
- Reset pulsed with 3 words in flight → next cycle out_valid=0. Only words accepted after reset appear at the output.
